wb_trace_fifo: RTL and testbench
================================

WB_TRACE_FIFO -- requirements
Module: wb_trace_fifo

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entry count; power of two, minimum 2.
REQ-002 Parameter CW, default 16, width of the cycle stamp and of the drop/collide counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 wb_regwrite  input  1  WB stage register-write strobe from cpu.
REQ-006 wb_regdata  input  32  WB stage write data from cpu.
REQ-007 mem_memread  input  1  MEM stage load strobe from cpu.
REQ-008 mem_memwrite  input  1  MEM stage store strobe from cpu.
REQ-009 mem_memdata  input  32  MEM stage memory data from cpu.
REQ-010 out_valid  output  1  head record available.
REQ-011 out_ready  input  1  consumer accepts head record.
REQ-012 out_kind  output  2  head record type: 00 WB write, 01 load, 10 store; 11 never produced.
REQ-013 out_data  output  32  head record data.
REQ-014 out_cycle  output  CW  cycle stamp of head record.
REQ-015 count  output  log2(DEPTH)+1  current occupancy.
REQ-016 overflow  output  1  sticky: at least one record lost to a full FIFO.
REQ-017 dropped  output  CW  saturating count of records lost to a full FIFO.
REQ-018 collide  output  CW  saturating count of lower-priority events discarded because of same-cycle arbitration.

Function
REQ-019 Cycle counter: CW bits, 0 in the first cycle after reset deassertion, +1 per cycle, wraps from all-ones to 0.
REQ-020 Event sampling: at each rising edge, at most one record is formed; priority wb_regwrite > mem_memwrite > mem_memread.
REQ-021 Record contents: kind per REQ-012; data = wb_regdata for WB, mem_memdata for load/store; cycle = counter value in the sampling cycle.
REQ-022 Each asserted strobe that loses arbitration in a cycle increments collide by 1 (two losers: +2); collide saturates at all-ones.
REQ-023 Pop: occurs when out_valid && out_ready at the rising edge; head advances by one.
REQ-024 Push: occurs when a record is formed and (count < DEPTH or pop in the same cycle).
REQ-025 Simultaneous push and pop when full: both occur; count stays DEPTH; no drop.
REQ-026 Simultaneous push and pop when count = 1: the new record becomes head next cycle; count stays 1.
REQ-027 Push when full without pop: the record is discarded, overflow set to 1, dropped +1 (saturating); FIFO contents unchanged.
REQ-028 out_valid = (count != 0); out_kind/out_data/out_cycle reflect the head entry whenever out_valid = 1; their values are don't-care when out_valid = 0.
REQ-029 Latency: an event sampled at edge N into an empty FIFO gives out_valid = 1 after edge N (same cycle the counter shows N+1's value).
REQ-030 out_ready while out_valid = 0 has no effect.
REQ-031 Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH; count tracks occupancy in 0..DEPTH.
REQ-032 Head outputs remain stable while out_valid = 1 and out_ready = 0.
REQ-033 overflow stays 1 until reset; it is not cleared by draining.

Reset
REQ-034 Reset asserted at an edge: count = 0, out_valid = 0, pointers = 0, overflow = 0, dropped = 0, collide = 0, cycle counter = 0, regardless of in-flight push/pop.
REQ-035 Strobes sampled at an edge where reset = 1 create no record and update no counter.
REQ-036 Reset mid-operation discards all stored records; the first post-reset event is stamped with its cycle count from 0.

Verification
REQ-037 Reset, then wb_regwrite=1, wb_regdata=0x0000_0005 for one cycle at cycle 3, out_ready=1 -> one record kind 00, data 0x5, cycle 3; out_valid high exactly one cycle.
REQ-038 Same cycle wb_regwrite=1 (0xA), mem_memwrite=1, mem_memread=1 -> single record kind 00 data 0xA; collide = 2.
REQ-039 out_ready=0, 10 consecutive store events data 1..10, DEPTH=8 -> count = 8, overflow = 1, dropped = 2; draining yields data 1..8 in order with increasing stamps.
REQ-040 FIFO full, out_ready=1 and a load event in the same cycle -> count stays 8, dropped unchanged, last record appears after seven more pops.
REQ-041 Hold out_ready=0 with 3 records, then assert reset one cycle -> count = 0, out_valid = 0, overflow = 0, counters 0; next event stamped from post-reset count.
REQ-042 Run 2^CW+3 idle cycles then one WB event -> stamp shows wrapped value 3 relative to reset-release cycle 0.

Source files
------------

// File: rtl/wb_trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_trace_fifo
//  Description : Captures CPU pipeline events (WB register writes, MEM loads,
//                MEM stores) as time-stamped trace records and buffers them in
//                a DEPTH-entry FIFO for a ready/valid consumer.
//
//  Ports
//    clk           : single clock, all state on rising edge
//    reset         : synchronous, active-high reset
//    wb_regwrite   : WB stage register-write strobe
//    wb_regdata    : WB stage write data
//    mem_memread   : MEM stage load strobe
//    mem_memwrite  : MEM stage store strobe
//    mem_memdata   : MEM stage memory data
//    out_valid     : head record available
//    out_ready     : consumer accepts head record
//    out_kind      : head record type (00 WB, 01 load, 10 store)
//    out_data      : head record data
//    out_cycle     : cycle stamp of head record
//    count         : current occupancy, 0..DEPTH
//    overflow      : sticky flag, a record was lost to a full FIFO
//    dropped       : saturating count of records lost to a full FIFO
//    collide       : saturating count of events lost to same-cycle arbitration
//
//  Parameters
//    DEPTH : FIFO entry count, power of two, minimum 2
//    CW    : width of the cycle stamp and the drop/collide counters
//
//  Revision    : 1.0  initial release
// ============================================================================
module wb_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int CW    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_regwrite,
    input  logic [31:0]              wb_regdata,
    input  logic                     mem_memread,
    input  logic                     mem_memwrite,
    input  logic [31:0]              mem_memdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out_kind,
    output logic [31:0]              out_data,
    output logic [CW-1:0]            out_cycle,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [CW-1:0]            dropped,
    output logic [CW-1:0]            collide
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0]    c_KIND_WB  = 2'b00;
    localparam logic [1:0]    c_KIND_LD  = 2'b01;
    localparam logic [1:0]    c_KIND_ST  = 2'b10;
    localparam logic [CW-1:0] c_CNT_MAX  = {CW{1'b1}};
    localparam logic [AW:0]   c_DEPTH    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] c_PTR_ONE  = AW'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CW-1:0] cyc_q,      cyc_d;
    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [AW:0]   count_q,    count_d;
    logic          overflow_q, overflow_d;
    logic [CW-1:0] dropped_q,  dropped_d;
    logic [CW-1:0] collide_q,  collide_d;

    // Record storage; no reset needed since count gates visibility.
    logic [1:0]    kind_mem  [DEPTH];
    logic [31:0]   data_mem  [DEPTH];
    logic [CW-1:0] stamp_mem [DEPTH];

    // ------------------------------------------------------------------
    // Event arbitration: WB write > store > load. Every asserted strobe
    // that is not the winner counts as one collision.
    // ------------------------------------------------------------------
    logic          w_rec_valid;
    logic [1:0]    w_rec_kind;
    logic [31:0]   w_rec_data;
    logic [1:0]    w_losers;

    always_comb begin
        w_rec_valid = wb_regwrite | mem_memwrite | mem_memread;
        w_rec_kind  = c_KIND_WB;
        w_rec_data  = wb_regdata;
        w_losers    = 2'd0;
        if (wb_regwrite) begin
            w_losers = {1'b0, mem_memwrite} + {1'b0, mem_memread};
        end else if (mem_memwrite) begin
            w_rec_kind = c_KIND_ST;
            w_rec_data = mem_memdata;
            w_losers   = {1'b0, mem_memread};
        end else if (mem_memread) begin
            w_rec_kind = c_KIND_LD;
            w_rec_data = mem_memdata;
        end
    end

    // ------------------------------------------------------------------
    // FIFO control. A pop frees a slot in the same cycle, so a full FIFO
    // that is being drained still accepts the new record.
    // ------------------------------------------------------------------
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == c_DEPTH);
    assign w_pop   = !w_empty && out_ready;
    assign w_push  = w_rec_valid && (!w_full || w_pop);
    assign w_drop  = w_rec_valid && w_full && !w_pop;

    // Collision counter adds 0..2 per cycle; one extra bit detects
    // saturation.
    logic [CW:0] w_coll_sum;
    assign w_coll_sum = {1'b0, collide_q} + (CW+1)'(w_losers);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        cyc_d      = cyc_q + CW'(1);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | w_drop;
        dropped_d  = dropped_q;
        collide_d  = w_coll_sum[CW] ? c_CNT_MAX : w_coll_sum[CW-1:0];

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CNT_ONE;
            2'b01:   count_d = count_q - c_CNT_ONE;
            default: count_d = count_q;
        endcase

        if (w_drop && (dropped_q != c_CNT_MAX)) begin
            dropped_d = dropped_q + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= '0;
            collide_q  <= '0;
        end else begin
            cyc_q      <= cyc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
            collide_q  <= collide_d;
        end
    end

    // Record storage write port; the stamp is the counter value of the
    // sampling cycle.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            kind_mem[wr_ptr_q]  <= w_rec_kind;
            data_mem[wr_ptr_q]  <= w_rec_data;
            stamp_mem[wr_ptr_q] <= cyc_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid = !w_empty;
    assign out_kind  = kind_mem[rd_ptr_q];
    assign out_data  = data_mem[rd_ptr_q];
    assign out_cycle = stamp_mem[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign dropped   = dropped_q;
    assign collide   = collide_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_trace_fifo
//  Description : Self-checking bench for wb_trace_fifo with directed scenarios
//                and randomized traffic against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_trace_fifo;

    localparam int DEPTH = 8;
    localparam int CW    = 8;
    localparam int MAXV  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wb_regwrite = 1'b0;
    logic [31:0]   wb_regdata = '0;
    logic          mem_memread = 1'b0;
    logic          mem_memwrite = 1'b0;
    logic [31:0]   mem_memdata = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [1:0]    out_kind;
    logic [31:0]   out_data;
    logic [CW-1:0] out_cycle;
    logic [3:0]    count;
    logic          overflow;
    logic [CW-1:0] dropped;
    logic [CW-1:0] collide;

    wb_trace_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .wb_regwrite  (wb_regwrite),
        .wb_regdata   (wb_regdata),
        .mem_memread  (mem_memread),
        .mem_memwrite (mem_memwrite),
        .mem_memdata  (mem_memdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_kind     (out_kind),
        .out_data     (out_data),
        .out_cycle    (out_cycle),
        .count        (count),
        .overflow     (overflow),
        .dropped      (dropped),
        .collide      (collide)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: a queue of records plus plain integer counters.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [1:0]    k;
        logic [31:0]   d;
        logic [CW-1:0] c;
    } rec_t;

    rec_t q[$];
    int   m_cyc  = 0;
    bit   m_ovf  = 0;
    int   m_drop = 0;
    int   m_coll = 0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic clear_strobes();
        wb_regwrite  = 1'b0;
        mem_memwrite = 1'b0;
        mem_memread  = 1'b0;
    endtask

    // Advance one clock; the model consumes the inputs seen at the edge.
    task automatic tick();
        bit   pop;
        bit   have;
        rec_t r;
        int   losers;
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_cyc  = 0;
            m_ovf  = 0;
            m_drop = 0;
            m_coll = 0;
        end else begin
            pop    = (q.size() != 0) && out_ready;
            have   = wb_regwrite || mem_memwrite || mem_memread;
            losers = int'(wb_regwrite) + int'(mem_memwrite) + int'(mem_memread) - (have ? 1 : 0);
            r.c    = CW'(m_cyc);
            if (wb_regwrite) begin
                r.k = 2'b00; r.d = wb_regdata;
            end else if (mem_memwrite) begin
                r.k = 2'b10; r.d = mem_memdata;
            end else begin
                r.k = 2'b01; r.d = mem_memdata;
            end
            m_coll = (m_coll + losers > MAXV) ? MAXV : m_coll + losers;
            if (pop) void'(q.pop_front());
            if (have) begin
                if (q.size() < DEPTH) q.push_back(r);
                else begin
                    m_ovf  = 1;
                    m_drop = (m_drop == MAXV) ? MAXV : m_drop + 1;
                end
            end
            m_cyc = (m_cyc + 1) % (1 << CW);
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_strobes();
        tick();
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        n_checks++; if (count !== 4'd0)   $display("FAIL rst_count: got %0d exp 0", count); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b exp 0", out_valid); else n_pass++;
        n_checks++; if ({overflow, dropped, collide} !== '0)
            $display("FAIL rst_flags: got ovf=%b drop=%0d coll=%0d exp 0", overflow, dropped, collide); else n_pass++;
    endtask

    task automatic test_single_wb();
        do_reset();
        out_ready = 1'b1;
        repeat (3) tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL wb_pre_valid: got %b exp 0", out_valid); else n_pass++;
        wb_regwrite = 1'b1; wb_regdata = 32'h0000_0005;
        tick();
        clear_strobes();
        n_checks++; if ({out_valid, out_kind, out_data, out_cycle} !== {1'b1, 2'b00, 32'h5, 8'd3})
            $display("FAIL wb_record: got v=%b k=%b d=%h c=%0d exp v=1 k=00 d=5 c=3",
                     out_valid, out_kind, out_data, out_cycle); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL wb_one_cycle: got %b exp 0", out_valid); else n_pass++;
    endtask

    task automatic test_collide();
        do_reset();
        out_ready = 1'b0;
        wb_regwrite = 1'b1; wb_regdata = 32'hA;
        mem_memwrite = 1'b1; mem_memread = 1'b1; mem_memdata = 32'h77;
        tick();
        wb_regwrite = 1'b0;
        tick();
        clear_strobes();
        n_checks++; if ({count, out_kind, out_data} !== {4'd2, 2'b00, 32'hA})
            $display("FAIL coll_head: got n=%0d k=%b d=%h exp n=2 k=00 d=a", count, out_kind, out_data); else n_pass++;
        n_checks++; if (collide !== 8'd3) $display("FAIL coll_count: got %0d exp 3", collide); else n_pass++;
        out_ready = 1'b1;
        tick();
        n_checks++; if ({out_kind, out_data} !== {2'b10, 32'h77})
            $display("FAIL coll_store_wins: got k=%b d=%h exp k=10 d=77", out_kind, out_data); else n_pass++;
    endtask

    task automatic test_push_pop_one();
        do_reset();
        out_ready = 1'b1;
        tick();
        n_checks++; if (count !== 4'd0) $display("FAIL ready_empty: got %0d exp 0", count); else n_pass++;
        out_ready = 1'b0;
        mem_memwrite = 1'b1; mem_memdata = 32'h11;
        tick();
        clear_strobes();
        out_ready = 1'b1;
        mem_memread = 1'b1; mem_memdata = 32'h22;
        tick();
        clear_strobes();
        n_checks++; if ({count, out_kind, out_data} !== {4'd1, 2'b01, 32'h22})
            $display("FAIL pp_one: got n=%0d k=%b d=%h exp n=1 k=01 d=22", count, out_kind, out_data); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL pp_one_drain: got %b exp 0", out_valid); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [CW-1:0] prev;
        do_reset();
        out_ready = 1'b0;
        for (int d = 1; d <= 10; d++) begin
            mem_memwrite = 1'b1; mem_memdata = 32'(d);
            tick();
        end
        clear_strobes();
        n_checks++; if ({count, overflow, dropped} !== {4'd8, 1'b1, 8'd2})
            $display("FAIL ovf_state: got n=%0d ovf=%b drop=%0d exp n=8 ovf=1 drop=2", count, overflow, dropped); else n_pass++;
        n_checks++; if (out_data !== 32'd1) $display("FAIL ovf_head: got %0d exp 1", out_data); else n_pass++;
        prev = out_cycle;
        // full + pop + load in the same cycle
        out_ready = 1'b1;
        mem_memread = 1'b1; mem_memdata = 32'hBEEF;
        tick();
        clear_strobes();
        n_checks++; if ({count, dropped} !== {4'd8, 8'd2})
            $display("FAIL full_pushpop: got n=%0d drop=%0d exp n=8 drop=2", count, dropped); else n_pass++;
        for (int k = 0; k < 7; k++) begin
            n_checks++; if (out_data !== 32'(k + 2) || out_cycle <= prev)
                $display("FAIL drain_order: got d=%0d c=%0d exp d=%0d c>%0d", out_data, out_cycle, k + 2, prev); else n_pass++;
            prev = out_cycle;
            tick();
        end
        n_checks++; if ({count, out_kind, out_data} !== {4'd1, 2'b01, 32'hBEEF})
            $display("FAIL late_load: got n=%0d k=%b d=%h exp n=1 k=01 d=beef", count, out_kind, out_data); else n_pass++;
        tick();
        n_checks++; if ({count, overflow} !== {4'd0, 1'b1})
            $display("FAIL ovf_sticky: got n=%0d ovf=%b exp n=0 ovf=1", count, overflow); else n_pass++;
    endtask

    // Runs straight after test_overflow so the flags are non-zero.
    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wb_regwrite = 1'b1; wb_regdata = 32'(100 + i); mem_memread = 1'b1;
            tick();
        end
        clear_strobes();
        n_checks++; if ({count, collide} !== {4'd3, 8'd3})
            $display("FAIL mid_pre: got n=%0d coll=%0d exp n=3 coll=3", count, collide); else n_pass++;
        reset = 1'b1;
        out_ready = 1'b1;
        wb_regwrite = 1'b1; mem_memwrite = 1'b1; mem_memread = 1'b1;
        tick();
        reset = 1'b0;
        clear_strobes();
        out_ready = 1'b0;
        n_checks++; if ({count, out_valid, overflow, dropped, collide} !== '0)
            $display("FAIL mid_reset: got n=%0d v=%b ovf=%b drop=%0d coll=%0d exp all 0",
                     count, out_valid, overflow, dropped, collide); else n_pass++;
        tick();
        tick();
        wb_regwrite = 1'b1; wb_regdata = 32'hC0DE;
        tick();
        clear_strobes();
        n_checks++; if ({count, out_data, out_cycle} !== {4'd1, 32'hC0DE, 8'd2})
            $display("FAIL mid_stamp: got n=%0d d=%h c=%0d exp n=1 d=c0de c=2", count, out_data, out_cycle); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b0;
        repeat ((1 << CW) + 3) tick();
        wb_regwrite = 1'b1; wb_regdata = 32'h99;
        tick();
        clear_strobes();
        n_checks++; if ({out_valid, out_cycle} !== {1'b1, 8'd3})
            $display("FAIL wrap_stamp: got v=%b c=%0d exp v=1 c=3", out_valid, out_cycle); else n_pass++;
    endtask

    task automatic test_saturate();
        do_reset();
        out_ready = 1'b0;
        wb_regwrite = 1'b1; mem_memwrite = 1'b1; mem_memread = 1'b1;
        repeat (300) tick();
        clear_strobes();
        n_checks++; if ({collide, dropped} !== {8'hFF, 8'hFF})
            $display("FAIL saturate: got coll=%0d drop=%0d exp 255 255", collide, dropped); else n_pass++;
        n_checks++; if ({count, overflow} !== {4'd8, 1'b1})
            $display("FAIL sat_state: got n=%0d ovf=%b exp n=8 ovf=1", count, overflow); else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset        = ($urandom_range(0, 99) == 0);
            wb_regwrite  = ($urandom_range(0, 3) == 0);
            mem_memwrite = ($urandom_range(0, 3) == 0);
            mem_memread  = ($urandom_range(0, 3) == 0);
            wb_regdata   = $urandom;
            mem_memdata  = $urandom;
            out_ready    = ($urandom_range(0, 2) != 0) ? (i % 97 > 40) : 1'b0;
            tick();
            n_checks++; if (count !== 4'(q.size()) || out_valid !== (q.size() != 0))
                $display("FAIL rnd_occ[%0d]: got n=%0d v=%b exp n=%0d", i, count, out_valid, q.size()); else n_pass++;
            if (q.size() != 0) begin
                n_checks++; if ({out_kind, out_data, out_cycle} !== q[0])
                    $display("FAIL rnd_head[%0d]: got k=%b d=%h c=%0d exp k=%b d=%h c=%0d",
                             i, out_kind, out_data, out_cycle, q[0].k, q[0].d, q[0].c); else n_pass++;
            end
            n_checks++; if ({overflow, dropped, collide} !== {m_ovf, CW'(m_drop), CW'(m_coll)})
                $display("FAIL rnd_flags[%0d]: got ovf=%b drop=%0d coll=%0d exp ovf=%b drop=%0d coll=%0d",
                         i, overflow, dropped, collide, m_ovf, m_drop, m_coll); else n_pass++;
        end
        reset = 1'b0;
        clear_strobes();
    endtask

    initial begin
        test_reset();
        test_single_wb();
        test_collide();
        test_push_pop_one();
        test_overflow();
        test_reset_mid();
        test_wrap();
        test_saturate();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
